// File: rtl/shift_pkg.sv
// shift_pkg: mode encodings and FSM state type shared by the shift unit.
package shift_pkg;
   localparam logic [1:0] MODE_LOG = 2'b00;
   localparam logic [1:0] MODE_ARI = 2'b01;
   localparam logic [1:0] MODE_ROT = 2'b10;
   localparam logic [1:0] MODE_SER = 2'b11;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit shift of q in the selected direction and mode, plus the bit shifted out.
module shift_step
   import shift_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] q,
   input  logic         dir,
   input  logic [1:0]   mode,
   input  logic         ser_in,
   output logic [N-1:0] nq,
   output logic         out_bit
);
   logic fill;
   always_comb begin
      out_bit = dir ? q[N-1] : q[0];
      fill = mode == MODE_SER ? ser_in :
             mode == MODE_ROT ? out_bit :
             mode == MODE_ARI ? (!dir && q[N-1]) : 1'b0;
      nq = dir ? {q[N-2:0], fill} : {fill, q[N-1:1]};
   end
endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter that loads a word, then shifts it one bit per enabled cycle.
module seq_shift_unit
   import shift_pkg::*;
#(
   parameter int N  = 32,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic          en,
   input  logic          dir,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] amt,
   input  logic [N-1:0]  in,
   input  logic          ser_in,
   output logic [N-1:0]  q,
   output logic          ser_out,
   output logic          busy,
   output logic          done
);
   state_t        state;
   logic          dir_r;
   logic [1:0]    mode_r;
   logic [AW-1:0] cnt;
   logic [N-1:0]  nq;
   logic          out_bit;

   shift_step #(.N(N)) u_step (
      .q(q), .dir(dir_r), .mode(mode_r), .ser_in(ser_in), .nq(nq), .out_bit(out_bit)
   );

   assign busy = state == SHIFT;
   assign done = state == DONE;

   always_ff @(posedge clk) begin
      if (clr) begin
         q       <= '0;
         ser_out <= 1'b0;
         cnt     <= '0;
         dir_r   <= 1'b0;
         mode_r  <= MODE_LOG;
         state   <= IDLE;
      end else if (state == SHIFT) begin
         if (en) begin
            q       <= nq;
            ser_out <= out_bit;
            cnt     <= cnt - 1'b1;
            if (cnt == AW'(1)) state <= DONE;
         end
      end else if (start) begin
         // amt of zero goes straight to DONE so busy never rises
         q      <= in;
         dir_r  <= dir;
         mode_r <= mode;
         cnt    <= amt;
         state  <= amt == '0 ? DONE : SHIFT;
      end else begin
         state <= IDLE;
      end
   end
endmodule
